// File: rtl/transport_arbiter.sv
// Transport-window arbiter: grants bus or train (never both) while transport is open.
// Each grant is bounded by HOLD_CYC cycles and followed by GAP_CYC dead cycles.
module transport_arbiter #(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             transport_req,
  input  logic             bus_req,
  input  logic             train_req,
  output logic             transport,
  output logic             bus,
  output logic             train,
  output logic [CNT_W-1:0] grant_cnt
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int GW = (GAP_CYC  > 1) ? $clog2(GAP_CYC)  : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_OPEN  = 3'd1;
  localparam logic [2:0] S_BUS   = 3'd2;
  localparam logic [2:0] S_TRAIN = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLD_CYC - 1);
  localparam logic [GW-1:0]    GAP_LOAD  = GW'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             last_bus_q, last_bus_d;  // 1: bus held the most recent grant
  logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;

  // Unknown request levels count as "not requesting".
  logic treq, breq, rreq;
  assign treq = (transport_req === 1'b1);
  assign breq = (bus_req       === 1'b1);
  assign rreq = (train_req     === 1'b1);

  logic own_req;
  assign own_req = (state_q == S_BUS) ? breq : rreq;

  logic [CNT_W-1:0] grant_cnt_inc;
  assign grant_cnt_inc = (grant_cnt_q == '1) ? grant_cnt_q : grant_cnt_q + CNT_ONE;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    gap_d       = gap_q;
    last_bus_d  = last_bus_q;
    grant_cnt_d = grant_cnt_q;
    if (!treq) begin
      // Window closed: abandon any grant immediately, no gap.
      state_d = S_IDLE;
      hold_d  = '0;
      gap_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_OPEN;
        S_OPEN: begin
          if (breq && (!rreq || !last_bus_q)) begin
            state_d     = S_BUS;
            hold_d      = HOLD_LOAD;
            last_bus_d  = 1'b1;
            grant_cnt_d = grant_cnt_inc;
          end else if (rreq) begin
            state_d     = S_TRAIN;
            hold_d      = HOLD_LOAD;
            last_bus_d  = 1'b0;
            grant_cnt_d = grant_cnt_inc;
          end
        end
        S_BUS, S_TRAIN: begin
          if (own_req && hold_q != '0) begin
            hold_d = hold_q - 1'b1;
          end else begin
            state_d = S_GAP;
            hold_d  = '0;
            gap_d   = GAP_LOAD;
          end
        end
        S_GAP: begin
          if (gap_q != '0) gap_d = gap_q - 1'b1;
          else             state_d = S_OPEN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      gap_q       <= '0;
      last_bus_q  <= 1'b0;
      grant_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      last_bus_q  <= last_bus_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  // Outputs decode registered state only, so reset clears them asynchronously.
  assign transport = (state_q != S_IDLE);
  assign bus       = (state_q == S_BUS);
  assign train     = (state_q == S_TRAIN);
  assign grant_cnt = grant_cnt_q;

`ifndef SYNTHESIS
  a_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    transport |-> !(bus && train));
  a_no_direct_swap: assert property (@(posedge clk) disable iff (!rst_n)
    bus |=> !train);
  a_no_direct_swap_t: assert property (@(posedge clk) disable iff (!rst_n)
    train |=> !bus);
`endif

endmodule

// File: tb/tb_transport_arbiter.sv
// Randomized and directed bench for transport_arbiter against a cycle-level reference model.
module tb_transport_arbiter;
  localparam int HOLD_CYC = 4;
  localparam int GAP_CYC  = 1;
  localparam int CNT_W    = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic clk, rst_n, transport_req, bus_req, train_req;
  logic transport, bus, train;
  logic [CNT_W-1:0] grant_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  transport_arbiter #(.HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .transport_req(transport_req), .bus_req(bus_req),
    .train_req(train_req), .transport(transport), .bus(bus), .train(train),
    .grant_cnt(grant_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout: bench did not finish, got time %0t required below 3000000", $time);
    $fatal(1, "timeout");
  end

  a_tb_exclusive: assert property (@(posedge clk) transport |-> !(bus && train));

  // Reference model: window open flag, current owner (0 none, 1 bus, 2 train),
  // cycles held so far, dead cycles remaining, last winner and total grants.
  bit m_win;
  int m_owner, m_held, m_gap, m_last, m_grants;

  task automatic model_reset();
    m_win = 0; m_owner = 0; m_held = 0; m_gap = 0; m_last = 2; m_grants = 0;
  endtask

  task automatic model_step(input logic t_in, input logic b_in, input logic r_in);
    bit t, b, r, own;
    int want;
    t = (t_in === 1'b1); b = (b_in === 1'b1); r = (r_in === 1'b1);
    if (!t) begin
      m_win = 0; m_owner = 0; m_held = 0; m_gap = 0;
    end else if (!m_win) begin
      m_win = 1;
    end else if (m_owner != 0) begin
      own = (m_owner == 1) ? b : r;
      if (own && m_held < HOLD_CYC) m_held++;
      else begin m_owner = 0; m_held = 0; m_gap = GAP_CYC; end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      if (b && r)  want = (m_last == 1) ? 2 : 1;
      else if (b)  want = 1;
      else if (r)  want = 2;
      else         want = 0;
      if (want != 0) begin
        m_owner = want; m_held = 1; m_last = want;
        if (m_grants < CNT_MAX) m_grants++;
      end
    end
  endtask

  function automatic logic [CNT_W+2:0] exp_out();
    logic eb, et;
    eb = (m_owner == 1);
    et = (m_owner == 2);
    return {m_win, eb, et, CNT_W'(m_grants)};
  endfunction

  // Advance one clock; model sees the same input values the DUT samples.
  task automatic tick();
    logic t, b, r;
    t = transport_req; b = bus_req; r = train_req;
    @(posedge clk);
    model_step(t, b, r);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; transport_req = 1'b0; bus_req = 1'b0; train_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({transport, bus, train, grant_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got %b required all zero", {transport, bus, train, grant_cnt});
    end
    transport_req = 1'b1;
    tick();
    n_checks++;
    if (transport !== 1'b1 || bus !== 1'b0 || train !== 1'b0 || grant_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_open: got t=%b b=%b r=%b cnt=%0d required t=1 b=0 r=0 cnt=0",
               transport, bus, train, grant_cnt);
    end
  endtask

  task automatic test_bus_hold();
    logic [6:0] seen;
    logic [6:0] want_pat;
    want_pat = 7'b1111001;
    bus_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      seen[6-i] = bus;
      n_checks++;
      if ({transport, bus, train, grant_cnt} !== exp_out()) begin
        n_fail++;
        $display("FAIL bus_hold cyc%0d: got %b required %b", i, {transport, bus, train, grant_cnt}, exp_out());
      end
    end
    n_checks++;
    if (seen !== want_pat || grant_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL bus_hold_pattern: got %b cnt=%0d required %b cnt=2", seen, grant_cnt, want_pat);
    end
    bus_req = 1'b0;
    repeat (4) begin
      tick();
      n_checks++;
      if ({transport, bus, train, grant_cnt} !== exp_out()) begin
        n_fail++;
        $display("FAIL bus_release: got %b required %b", {transport, bus, train, grant_cnt}, exp_out());
      end
    end
  endtask

  task automatic test_alternate();
    int order[$];
    logic pb, pr;
    do_reset();
    transport_req = 1'b1;
    tick();
    bus_req = 1'b1; train_req = 1'b1;
    pb = 1'b0; pr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (bus && !pb)   order.push_back(1);
      if (train && !pr) order.push_back(2);
      pb = bus; pr = train;
      n_checks++;
      if ({transport, bus, train, grant_cnt} !== exp_out() || (bus && train)) begin
        n_fail++;
        $display("FAIL alternate cyc%0d: got %b required %b", i, {transport, bus, train, grant_cnt}, exp_out());
      end
    end
    n_checks++;
    if (order.size() < 3 || order[0] != 1 || order[1] != 2 || order[2] != 1) begin
      n_fail++;
      $display("FAIL alternate_order: got %0d grants first=%0d required BUS,TRAIN,BUS",
               order.size(), (order.size() > 0) ? order[0] : 0);
    end
    bus_req = 1'b0; train_req = 1'b0;
  endtask

  task automatic test_train_drop();
    logic [4:0] got;
    do_reset();
    transport_req = 1'b1;
    tick();
    train_req = 1'b1;
    tick(); got[4] = train;
    tick(); got[3] = train;
    train_req = 1'b0; bus_req = 1'b1;
    tick(); got[2] = train | bus;
    tick(); got[1] = bus;
    tick(); got[0] = bus;
    n_checks++;
    if (got !== 5'b11001) begin
      n_fail++;
      $display("FAIL train_drop: got %b required 11001", got);
    end
    n_checks++;
    if ({transport, bus, train, grant_cnt} !== exp_out()) begin
      n_fail++;
      $display("FAIL train_drop_model: got %b required %b", {transport, bus, train, grant_cnt}, exp_out());
    end
    bus_req = 1'b0;
  endtask

  task automatic test_transport_drop();
    do_reset();
    transport_req = 1'b1;
    tick();
    bus_req = 1'b1;
    tick(); tick();
    transport_req = 1'b0;
    tick();
    n_checks++;
    if (transport !== 1'b0 || bus !== 1'b0 || train !== 1'b0) begin
      n_fail++;
      $display("FAIL transport_drop: got t=%b b=%b r=%b required 0 0 0", transport, bus, train);
    end
    transport_req = 1'b1;
    tick();
    n_checks++;
    if (transport !== 1'b1 || bus !== 1'b0) begin
      n_fail++;
      $display("FAIL transport_reopen: got t=%b b=%b required t=1 b=0", transport, bus);
    end
    tick();
    n_checks++;
    if ({transport, bus, train, grant_cnt} !== exp_out() || bus !== 1'b1) begin
      n_fail++;
      $display("FAIL transport_regrant: got %b required %b", {transport, bus, train, grant_cnt}, exp_out());
    end
    bus_req = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    transport_req = 1'b1;
    tick();
    train_req = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({transport, bus, train, grant_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_grant: got %b required all zero", {transport, bus, train, grant_cnt});
    end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if ({transport, bus, train, grant_cnt} !== exp_out()) begin
      n_fail++;
      $display("FAIL reset_recover: got %b required %b", {transport, bus, train, grant_cnt}, exp_out());
    end
    train_req = 1'b0;
  endtask

  task automatic test_x_inputs();
    do_reset();
    transport_req = 1'b1;
    tick();
    bus_req = 1'bx; train_req = 1'b0;
    tick();
    n_checks++;
    if (transport !== 1'b1 || bus !== 1'b0 || train !== 1'b0) begin
      n_fail++;
      $display("FAIL x_bus_req: got t=%b b=%b r=%b required 1 0 0", transport, bus, train);
    end
    bus_req = 1'b0; transport_req = 1'bx;
    tick();
    n_checks++;
    if (transport !== 1'b0) begin
      n_fail++;
      $display("FAIL x_transport_req: got t=%b required 0", transport);
    end
    transport_req = 1'b0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      transport_req = ($urandom_range(0, 19) != 0);
      bus_req       = $urandom_range(0, 1);
      train_req     = $urandom_range(0, 1);
      tick();
      n_checks++;
      if ({transport, bus, train, grant_cnt} !== exp_out()) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL random cyc%0d: got %b required %b", i, {transport, bus, train, grant_cnt}, exp_out());
        bad++;
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    transport_req = 1'b1;
    bus_req = 1'b1;
    train_req = 1'b0;
    for (int i = 0; i < 270 * (HOLD_CYC + GAP_CYC + 1); i++) begin
      tick();
      n_checks++;
      if (grant_cnt !== CNT_W'(m_grants) || bus !== (m_owner == 1)) begin
        n_fail++;
        $display("FAIL saturation cyc%0d: got cnt=%0d b=%b required cnt=%0d", i, grant_cnt, bus, m_grants);
      end
    end
    n_checks++;
    if (grant_cnt !== 8'hFF) begin
      n_fail++;
      $display("FAIL saturation_final: got %0d required 255", grant_cnt);
    end
    bus_req = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; transport_req = 1'b0; bus_req = 1'b0; train_req = 1'b0;
    model_reset();
    test_reset();
    test_bus_hold();
    test_alternate();
    test_train_drop();
    test_transport_drop();
    test_reset_mid_grant();
    test_x_inputs();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
